// File: rtl/svm_cpu_lsu_pkg.sv
// rtl/svm_cpu_lsu_pkg.sv - opcode, state and access-size types plus opcode decode helpers for the LSU
package svm_cpu_lsu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8,
    OP_ALU = 4'd9
  } opcode_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } access_size_t;

  typedef struct packed {
    logic         valid;
    logic         is_load;
    logic         sgn;
    access_size_t size;
  } op_info_t;

  // valid = 0 marks opcodes the LSU does not service
  function automatic op_info_t decode_op(input opcode_t op);
    op_info_t info;
    info = '0;
    case (op)
      OP_LB:   info = '{valid: 1'b1, is_load: 1'b1, sgn: 1'b1, size: SIZE_BYTE};
      OP_LBU:  info = '{valid: 1'b1, is_load: 1'b1, sgn: 1'b0, size: SIZE_BYTE};
      OP_LH:   info = '{valid: 1'b1, is_load: 1'b1, sgn: 1'b1, size: SIZE_HALF};
      OP_LHU:  info = '{valid: 1'b1, is_load: 1'b1, sgn: 1'b0, size: SIZE_HALF};
      OP_LW:   info = '{valid: 1'b1, is_load: 1'b1, sgn: 1'b0, size: SIZE_WORD};
      OP_SB:   info = '{valid: 1'b1, is_load: 1'b0, sgn: 1'b0, size: SIZE_BYTE};
      OP_SH:   info = '{valid: 1'b1, is_load: 1'b0, sgn: 1'b0, size: SIZE_HALF};
      OP_SW:   info = '{valid: 1'b1, is_load: 1'b0, sgn: 1'b0, size: SIZE_WORD};
      default: info = '0;
    endcase
    return info;
  endfunction

  function automatic logic is_misaligned(input access_size_t size, input logic [1:0] a);
    return ((size == SIZE_HALF) && a[0]) || ((size == SIZE_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/svm_cpu_lsu_lanes.sv
// rtl/svm_cpu_lsu_lanes.sv - little-endian byte-lane steering for stores and load extraction/extension
module svm_cpu_lsu_lanes
  import svm_cpu_lsu_pkg::*;
(
  input  access_size_t size,
  input  logic [1:0]   a,
  input  logic [31:0]  store_data,
  input  logic [31:0]  readdata,
  input  logic         sgn,
  output logic [3:0]   byteenable,
  output logic [31:0]  writedata,
  output logic [31:0]  load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte    = readdata[{a, 3'b000} +: 8];
    rd_half    = a[1] ? readdata[31:16] : readdata[15:0];
    byteenable = 4'b1111;
    writedata  = store_data;
    load_data  = readdata;
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << a;
        writedata  = {4{store_data[7:0]}};
        load_data  = {{24{sgn & rd_byte[7]}}, rd_byte};
      end
      SIZE_HALF: begin
        byteenable = a[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{store_data[15:0]}};
        load_data  = {{16{sgn & rd_half[15]}}, rd_half};
      end
      default: begin
        byteenable = 4'b1111;
        writedata  = store_data;
        load_data  = readdata;
      end
    endcase
  end

endmodule

// File: rtl/svm_cpu_lsu.sv
// rtl/svm_cpu_lsu.sv - load/store unit driving the data-side Avalon-MM port
// Optional alignment trap enabled by SVM_LSU_ALIGN_CHECK_EN (adds misaligned_o).
module svm_cpu_lsu
  import svm_cpu_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              start_i,
  input  opcode_t           op_i,
  input  logic [ADDR_W-1:0] effective_address_i,
  input  logic [31:0]       store_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       load_data_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_read_o,
  output logic              avm_write_o,
  output logic [3:0]        avm_byteenable_o,
  output logic [31:0]       avm_writedata_o,
  input  logic [31:0]       avm_readdata_i,
  input  logic              avm_waitrequest_i
`ifdef SVM_LSU_ALIGN_CHECK_EN
  ,
  output logic              misaligned_o
`endif
);

  lsu_state_t        state_q, state_d;
  op_info_t          info_in, info_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wd_q;
  logic [31:0]       load_q;
  logic              accept;
  logic              misalign_in;

  access_size_t      lane_size;
  logic [1:0]        lane_a;
  logic              lane_sgn;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wd;
  logic [31:0]       lane_ld;

  assign info_in = decode_op(op_i);
  assign accept  = (state_q == LSU_IDLE) && start_i && info_in.valid;

`ifdef SVM_LSU_ALIGN_CHECK_EN
  logic mis_q;
  assign misalign_in = is_misaligned(info_in.size, effective_address_i[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  // In IDLE the lanes shape the incoming store; afterwards they extract the load
  assign lane_size = (state_q == LSU_IDLE) ? info_in.size : info_q.size;
  assign lane_a    = (state_q == LSU_IDLE) ? effective_address_i[1:0] : addr_q[1:0];
  assign lane_sgn  = (state_q == LSU_IDLE) ? info_in.sgn : info_q.sgn;

  svm_cpu_lsu_lanes u_lanes (
    .size       (lane_size),
    .a          (lane_a),
    .store_data (store_data_i),
    .readdata   (avm_readdata_i),
    .sgn        (lane_sgn),
    .byteenable (lane_be),
    .writedata  (lane_wd),
    .load_data  (lane_ld)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= LSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:   if (accept) state_d = misalign_in ? LSU_DONE : LSU_ACCESS;
      LSU_ACCESS: if (!avm_waitrequest_i) state_d = LSU_DONE;
      LSU_DONE:   state_d = LSU_IDLE;
      default:    state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      info_q <= '0;
      addr_q <= '0;
      be_q   <= '0;
      wd_q   <= '0;
      load_q <= '0;
    end else begin
      if (accept) begin
        info_q <= info_in;
        addr_q <= effective_address_i;
        be_q   <= lane_be;
        wd_q   <= lane_wd;
      end
      if ((state_q == LSU_ACCESS) && !avm_waitrequest_i && info_q.is_load) begin
        load_q <= lane_ld;
      end
    end
  end

`ifdef SVM_LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= misalign_in;
    end
  end
`endif

  always_comb begin
    busy_o           = (state_q == LSU_ACCESS);
    done_o           = (state_q == LSU_DONE);
    avm_read_o       = (state_q == LSU_ACCESS) && info_q.is_load;
    avm_write_o      = (state_q == LSU_ACCESS) && !info_q.is_load;
    avm_address_o    = {addr_q[ADDR_W-1:2], 2'b00};
    avm_byteenable_o = be_q;
    avm_writedata_o  = wd_q;
    load_data_o      = load_q;
`ifdef SVM_LSU_ALIGN_CHECK_EN
    misaligned_o     = (state_q == LSU_DONE) && mis_q;
`endif
  end

endmodule

// File: tb/tb_svm_cpu_lsu.sv
// tb/tb_svm_cpu_lsu.sv - randomized self-checking bench for svm_cpu_lsu against a byte-memory reference
module tb_svm_cpu_lsu;
  import svm_cpu_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  opcode_t     op_i;
  logic [31:0] effective_address_i;
  logic [31:0] store_data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] load_data_o;
  logic [31:0] avm_address_o;
  logic        avm_read_o;
  logic        avm_write_o;
  logic [3:0]  avm_byteenable_o;
  logic [31:0] avm_writedata_o;
  logic [31:0] avm_readdata_i;
  logic        avm_waitrequest_i;
`ifdef SVM_LSU_ALIGN_CHECK_EN
  logic        misaligned_o;
`endif

  always #5 clk = ~clk;

  svm_cpu_lsu #(.ADDR_W(32)) dut (
    .clk                 (clk),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .op_i                (op_i),
    .effective_address_i (effective_address_i),
    .store_data_i        (store_data_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .load_data_o         (load_data_o),
    .avm_address_o       (avm_address_o),
    .avm_read_o          (avm_read_o),
    .avm_write_o         (avm_write_o),
    .avm_byteenable_o    (avm_byteenable_o),
    .avm_writedata_o     (avm_writedata_o),
    .avm_readdata_i      (avm_readdata_i),
    .avm_waitrequest_i   (avm_waitrequest_i)
`ifdef SVM_LSU_ALIGN_CHECK_EN
    ,
    .misaligned_o        (misaligned_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Slave memory (word view, driven by DUT bus cycles) and reference memory (byte view)
  logic [31:0] smem [0:255];
  logic [7:0]  rmem [0:1023];
  logic [31:0] last_load;

  int          o_done_k, o_done_cnt, o_busy, o_rd, o_wr, o_mis;
  logic [3:0]  o_be;
  logic [31:0] o_wd, o_addr;
  bit          o_stable;

  function automatic bit is_load_op(input opcode_t op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic int op_bytes(input opcode_t op);
    if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB)) return 1;
    if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) return 2;
    return 4;
  endfunction

  function automatic int base_of(input opcode_t op, input logic [31:0] addr);
    int n;
    n = op_bytes(op);
    return (int'(addr[9:0]) / n) * n;
  endfunction

  function automatic logic [3:0] ref_be(input opcode_t op, input logic [31:0] addr);
    int n, off;
    n   = op_bytes(op);
    off = base_of(op, addr) % 4;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_load(input opcode_t op, input logic [31:0] addr);
    int b;
    logic [31:0] v;
    b = base_of(op, addr);
    v = 32'd0;
    for (int i = 0; i < op_bytes(op); i++) v = v | (32'(rmem[b + i]) << (8 * i));
    if ((op == OP_LB) && v[7])  v = v - 32'd256;
    if ((op == OP_LH) && v[15]) v = v - 32'd65536;
    return v;
  endfunction

  function automatic bit ref_misaligned(input opcode_t op, input logic [31:0] addr);
`ifdef SVM_LSU_ALIGN_CHECK_EN
    return (op_bytes(op) > 1) && ((int'(addr[9:0]) % op_bytes(op)) != 0);
`else
    return (op == OP_NOP) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic ref_store(input opcode_t op, input logic [31:0] addr, input logic [31:0] sd);
    int b;
    b = base_of(op, addr);
    for (int i = 0; i < op_bytes(op); i++) rmem[b + i] = sd[8*i +: 8];
  endtask

  task automatic poke_word(input logic [31:0] addr, input logic [31:0] val);
    smem[addr[9:2]] = val;
    for (int j = 0; j < 4; j++) rmem[{addr[9:2], 2'b00} + j] = val[8*j +: 8];
  endtask

  // Issue one request and play the Avalon slave; cycle k=1 is the cycle after start is sampled
  task automatic run_access(input opcode_t op, input logic [31:0] addr, input logic [31:0] sd,
                            input int waits);
    bit seen;
    seen = 0;
    o_done_k = -1; o_done_cnt = 0; o_busy = 0; o_rd = 0; o_wr = 0; o_mis = 0;
    o_be = '0; o_wd = '0; o_addr = '0; o_stable = 1;
    @(negedge clk);
    start_i = 1'b1; op_i = op; effective_address_i = addr; store_data_i = sd;
    avm_waitrequest_i = 1'b0;
    for (int k = 1; k <= waits + 6; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      op_i = OP_NOP;
      avm_waitrequest_i = (k <= waits);
      if (avm_read_o || avm_write_o) begin
        if (!seen) begin
          seen = 1; o_be = avm_byteenable_o; o_wd = avm_writedata_o; o_addr = avm_address_o;
        end else if ((o_be !== avm_byteenable_o) || (o_wd !== avm_writedata_o) || (o_addr !== avm_address_o)) begin
          o_stable = 0;
        end
        if (avm_read_o) o_rd++;
        if (avm_write_o) o_wr++;
        avm_readdata_i = smem[avm_address_o[9:2]];
        if (avm_write_o && !avm_waitrequest_i) begin
          for (int j = 0; j < 4; j++)
            if (avm_byteenable_o[j]) smem[avm_address_o[9:2]][8*j +: 8] = avm_writedata_o[8*j +: 8];
        end
      end
      if (busy_o) o_busy++;
      if (done_o) begin
        o_done_cnt++;
        if (o_done_k < 0) o_done_k = k;
      end
`ifdef SVM_LSU_ALIGN_CHECK_EN
      if (misaligned_o) o_mis++;
`endif
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; op_i = OP_NOP; effective_address_i = '0; store_data_i = '0;
    avm_readdata_i = '0; avm_waitrequest_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1; op_i = OP_LW;
    @(negedge clk);
    vectors++;
    if ({busy_o, done_o, avm_read_o, avm_write_o} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ctrl: busy/done/rd/wr=%b expected 0000", {busy_o, done_o, avm_read_o, avm_write_o});
    end
    vectors++;
    if ({avm_address_o, avm_byteenable_o, avm_writedata_o} !== 68'd0) begin
      miscompares++; $display("FAIL reset_bus: addr=%h be=%b wd=%h expected zeros", avm_address_o, avm_byteenable_o, avm_writedata_o);
    end
    vectors++;
    if (load_data_o !== 32'd0) begin
      miscompares++; $display("FAIL reset_load: got %h expected 00000000", load_data_o);
    end
    start_i = 1'b0; op_i = OP_NOP;
    reset_i = 1'b0;
    last_load = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    run_access(OP_SW, 32'h0000_1000, 32'hDEAD_BEEF, 0);
    ref_store(OP_SW, 32'h0000_1000, 32'hDEAD_BEEF);
    vectors++;
    if (o_addr !== 32'h0000_1000) begin miscompares++; $display("FAIL sw_addr: got %h expected 00001000", o_addr); end
    vectors++;
    if (o_be !== 4'b1111) begin miscompares++; $display("FAIL sw_be: got %b expected 1111", o_be); end
    vectors++;
    if (o_wd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sw_wd: got %h expected deadbeef", o_wd); end
    vectors++;
    if ((o_wr !== 1) || (o_rd !== 0)) begin miscompares++; $display("FAIL sw_cycles: wr=%0d rd=%0d expected 1 0", o_wr, o_rd); end
    vectors++;
    if ((o_done_k !== 2) || (o_done_cnt !== 1)) begin
      miscompares++; $display("FAIL sw_done: cycle=%0d pulses=%0d expected 2 1", o_done_k, o_done_cnt);
    end
    vectors++;
    if (load_data_o !== last_load) begin miscompares++; $display("FAIL sw_load_hold: got %h expected %h", load_data_o, last_load); end
  endtask

  task automatic test_load_byte();
    poke_word(32'h0000_1003, 32'h80FF_1234);
    run_access(OP_LB, 32'h0000_1003, 32'h0, 0);
    vectors++;
    if (o_be !== 4'b1000) begin miscompares++; $display("FAIL lb_be: got %b expected 1000", o_be); end
    vectors++;
    if (load_data_o !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_data: got %h expected ffffff80", load_data_o); end
    vectors++;
    if ((o_rd !== 1) || (o_done_k !== 2)) begin miscompares++; $display("FAIL lb_timing: rd=%0d done=%0d expected 1 2", o_rd, o_done_k); end
    run_access(OP_LBU, 32'h0000_1003, 32'h0, 0);
    vectors++;
    if (load_data_o !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_data: got %h expected 00000080", load_data_o); end
    last_load = 32'h0000_0080;
  endtask

  task automatic test_load_half();
    poke_word(32'h0000_2002, 32'h8001_7FFF);
    run_access(OP_LH, 32'h0000_2002, 32'h0, 0);
    vectors++;
    if (o_be !== 4'b1100) begin miscompares++; $display("FAIL lh_be: got %b expected 1100", o_be); end
    vectors++;
    if (load_data_o !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_data: got %h expected ffff8001", load_data_o); end
    run_access(OP_LHU, 32'h0000_2002, 32'h0, 0);
    vectors++;
    if (load_data_o !== 32'h0000_8001) begin miscompares++; $display("FAIL lhu_data: got %h expected 00008001", load_data_o); end
    last_load = 32'h0000_8001;
  endtask

  task automatic test_wait_states();
    run_access(OP_SB, 32'h0000_0001, 32'h0000_005A, 3);
    ref_store(OP_SB, 32'h0000_0001, 32'h0000_005A);
    vectors++;
    if ((o_addr !== 32'h0) || (o_be !== 4'b0010) || (o_wd !== 32'h5A5A_5A5A)) begin
      miscompares++; $display("FAIL sb_ws_bus: addr=%h be=%b wd=%h expected 00000000 0010 5a5a5a5a", o_addr, o_be, o_wd);
    end
    vectors++;
    if (!o_stable) begin miscompares++; $display("FAIL sb_ws_stable: got 0 expected 1"); end
    vectors++;
    if ((o_busy !== 4) || (o_wr !== 4)) begin miscompares++; $display("FAIL sb_ws_busy: busy=%0d wr=%0d expected 4 4", o_busy, o_wr); end
    vectors++;
    if ((o_done_cnt !== 1) || (o_done_k !== 5)) begin
      miscompares++; $display("FAIL sb_ws_done: pulses=%0d cycle=%0d expected 1 5", o_done_cnt, o_done_k);
    end
    vectors++;
    if (load_data_o !== last_load) begin miscompares++; $display("FAIL sb_load_hold: got %h expected %h", load_data_o, last_load); end
  endtask

  task automatic test_reset_mid_access();
    bit saw_done;
    saw_done = 0;
    poke_word(32'h0000_0040, 32'hCAFE_F00D);
    @(negedge clk);
    start_i = 1'b1; op_i = OP_LW; effective_address_i = 32'h0000_0040; avm_waitrequest_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; op_i = OP_NOP;
    vectors++;
    if (avm_read_o !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre: read=%b expected 1", avm_read_o); end
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    vectors++;
    if ({avm_read_o, busy_o, done_o} !== 3'b000) begin
      miscompares++; $display("FAIL rst_mid_drop: rd/busy/done=%b expected 000", {avm_read_o, busy_o, done_o});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 1) reset_i = 1'b0;
      if (done_o || avm_read_o) saw_done = 1;
    end
    avm_waitrequest_i = 1'b0;
    vectors++;
    if (saw_done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_quiet: activity=%b expected 0", saw_done); end
    last_load = 32'd0;
    run_access(OP_LW, 32'h0000_0040, 32'h0, 0);
    vectors++;
    if ((load_data_o !== 32'hCAFE_F00D) || (o_done_k !== 2)) begin
      miscompares++; $display("FAIL rst_mid_after: data=%h done=%0d expected cafef00d 2", load_data_o, o_done_k);
    end
    last_load = 32'hCAFE_F00D;
  endtask

  task automatic test_ignored_op();
    run_access(OP_ALU, 32'h0000_0100, 32'h1234_5678, 0);
    vectors++;
    if ((o_busy !== 0) || (o_done_cnt !== 0) || (o_rd + o_wr !== 0)) begin
      miscompares++; $display("FAIL ignored_op: busy=%0d done=%0d bus=%0d expected 0 0 0", o_busy, o_done_cnt, o_rd + o_wr);
    end
  endtask

`ifdef SVM_LSU_ALIGN_CHECK_EN
  task automatic test_misaligned();
    run_access(OP_LW, 32'h0000_0002, 32'h0, 0);
    vectors++;
    if ((o_rd + o_wr !== 0) || (o_done_k !== 1) || (o_mis !== 1)) begin
      miscompares++; $display("FAIL misaligned_lw: bus=%0d done=%0d mis=%0d expected 0 1 1", o_rd + o_wr, o_done_k, o_mis);
    end
    vectors++;
    if (load_data_o !== last_load) begin miscompares++; $display("FAIL misaligned_hold: got %h expected %h", load_data_o, last_load); end
  endtask
`endif

  task automatic test_random();
    opcode_t     ops [8];
    opcode_t     op;
    logic [31:0] addr, sd, exp;
    logic [3:0]  ebe;
    int          waits;
    bit          mis;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    for (int n = 0; n < 60; n++) begin
      op    = ops[$urandom_range(0, 7)];
      addr  = {22'd0, 10'($urandom)};
      sd    = $urandom;
      waits = $urandom_range(0, 3);
      mis   = ref_misaligned(op, addr);
      run_access(op, addr, sd, waits);
      if (mis) begin
        vectors++;
        if ((o_rd + o_wr !== 0) || (o_done_k !== 1) || (o_mis !== 1) || (load_data_o !== last_load)) begin
          miscompares++; $display("FAIL rnd_mis[%0d]: bus=%0d done=%0d mis=%0d ld=%h", n, o_rd + o_wr, o_done_k, o_mis, load_data_o);
        end
        continue;
      end
      ebe = ref_be(op, addr);
      vectors++;
      if ((o_be !== ebe) || (o_addr !== {addr[31:2], 2'b00}) || !o_stable) begin
        miscompares++; $display("FAIL rnd_bus[%0d]: be=%b addr=%h stable=%b expected %b %h 1", n, o_be, o_addr, o_stable, ebe, {addr[31:2], 2'b00});
      end
      vectors++;
      if ((o_done_k !== waits + 2) || (o_done_cnt !== 1) || (o_busy !== waits + 1)) begin
        miscompares++; $display("FAIL rnd_timing[%0d]: done=%0d pulses=%0d busy=%0d expected %0d 1 %0d", n, o_done_k, o_done_cnt, o_busy, waits + 2, waits + 1);
      end
      if (is_load_op(op)) begin
        exp = ref_load(op, addr);
        vectors++;
        if (load_data_o !== exp) begin miscompares++; $display("FAIL rnd_load[%0d]: op=%0d addr=%h got %h expected %h", n, op, addr, load_data_o, exp); end
        last_load = exp;
      end else begin
        ref_store(op, addr, sd);
        for (int j = 0; j < 4; j++) begin
          if (ebe[j]) begin
            vectors++;
            if (o_wd[8*j +: 8] !== rmem[{addr[9:2], 2'b00} + j]) begin
              miscompares++; $display("FAIL rnd_wlane[%0d]: lane %0d got %h expected %h", n, j, o_wd[8*j +: 8], rmem[{addr[9:2], 2'b00} + j]);
            end
          end
        end
        vectors++;
        if (load_data_o !== last_load) begin miscompares++; $display("FAIL rnd_hold[%0d]: got %h expected %h", n, load_data_o, last_load); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) poke_word(32'(i * 4), $urandom);
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half();
    test_wait_states();
    test_reset_mid_access();
    test_ignored_op();
`ifdef SVM_LSU_ALIGN_CHECK_EN
    test_misaligned();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/svm_cpu_lsu.md
Name: svm_cpu_lsu

Overview:
- Load/store unit: consumes the effective address, store data and opcode from the ALU and performs the access on the data-side Avalon-MM bus.
- Generates byte enables and lane-shifted write data; extracts, sign/zero-extends and registers load data for rt writeback.
- Provides a busy/stall indication to the CPU control FSM.
- Sits between the ALU/register file and the data memory port.

Parameters:
- ADDR_W, 32, width of byte address input and bus address output.

Ports:
- clk  input  1  core clock
- reset_i  input  1  asynchronous, active-high reset
- start_i  input  1  request: begin access described by op_i/effective_address_i/store_data_i
- op_i  input  opcode_t  one of OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
- effective_address_i  input  ADDR_W  byte address (rs + sext(imm))
- store_data_i  input  32  rt value, right-justified (byte in [7:0], half in [15:0])
- busy_o  output  1  access in flight; CPU must stall
- done_o  output  1  one-cycle pulse on access completion
- load_data_o  output  32  extended load result, valid from done_o onward
- avm_address_o  output  ADDR_W  word-aligned address (bits [1:0] = 0)
- avm_read_o  output  1  Avalon read
- avm_write_o  output  1  Avalon write
- avm_byteenable_o  output  4  byte lanes
- avm_writedata_o  output  32  lane-shifted write data
- avm_readdata_i  input  32  read data, valid when avm_read_o && !avm_waitrequest_i
- avm_waitrequest_i  input  1  slave stall

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - busy_o, done_o, avm_read_o, avm_write_o = 0.
  - avm_address_o, avm_byteenable_o, avm_writedata_o, load_data_o = 0.
  - Reset mid-access drops read/write at once. No completion pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - start_i with a load/store op: latch op, address and store data; go to ACCESS.
  - start_i with any other op: ignored, stay IDLE.
- ACCESS:
  - busy_o = 1; avm_read_o or avm_write_o = 1.
  - Address, byteenable and writedata are registered and held stable while avm_waitrequest_i = 1.
  - On a rising edge with avm_waitrequest_i = 0: go to DONE; for loads, capture the extended readdata into load_data_o.
- DONE:
  - done_o = 1 and busy_o = 0 for exactly one cycle; read/write = 0.
  - Next cycle: IDLE.
  - start_i asserted in DONE is ignored; the CPU reissues it in IDLE.
- Latency:
  - start_i sampled at edge N → request visible in cycle N+1.
  - With no wait states, done_o is high in cycle N+2.
  - Each wait-state cycle adds 1.
- Byte lanes are little-endian; a = effective_address[1:0].
  - Byte access: byteenable = 4'b0001 << a; writedata = {4{store_data[7:0]}}.
  - Half access: byteenable = a[1] ? 4'b1100 : 4'b0011; writedata = {2{store_data[15:0]}}.
  - Word access: byteenable = 4'b1111; writedata = store_data.
  - LB/LBU: readdata byte lane a, sign- or zero-extended to 32 bits.
  - LH/LHU: half lane a[1], sign- or zero-extended to 32 bits.
  - LW: full word.
- load_data_o holds its value until the next load completes. Stores never modify it.
- Misalignment without the optional feature: ignored address bits are dropped (LH uses a[1] only; LW ignores a). The access proceeds normally.
- busy_o is registered, high in ACCESS only.

Optional Feature:
- Macro: SVM_LSU_ALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned_o.
  - A half access with a[0] = 1, or a word access with a != 0, issues no bus cycle: ACCESS is skipped and the FSM goes straight to DONE.
  - misaligned_o pulses together with done_o; load_data_o is unchanged.
- Undefined: no misaligned_o port; behaviour as in the Misalignment bullet above.

Decomposition:
- Package codes gains:
  - lsu_state_t enum (LSU_IDLE, LSU_ACCESS, LSU_DONE).
  - access_size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - A function mapping opcode_t to access_size_t and a signed/unsigned flag.
- Sub-module svm_cpu_lsu_lanes: purely combinational.
  - Inputs: size, a, store_data, readdata, signed flag.
  - Outputs: byteenable, writedata, extended load data.
- The FSM stays in svm_cpu_lsu.

Test Plan:
1. SW at 0x1000, data 0xDEADBEEF, waitrequest=0 → addr 0x1000, be 4'b1111, writedata 0xDEADBEEF, write high exactly 1 cycle, done_o at start+2.
2. LB at 0x1003 with readdata 0x80FF_1234 → be 4'b1000, load_data_o 0xFFFFFF80. Repeat with LBU → 0x00000080.
3. LH at 0x2002 with readdata 0x8001_7FFF → be 4'b1100, load_data_o 0xFFFF8001. LHU → 0x00008001.
4. SB 0x5A at 0x0001 with waitrequest held 3 cycles → address/be 4'b0010/writedata 0x5A5A5A5A stable throughout, busy_o high 4 cycles, single done_o pulse.
5. Assert reset_i during a wait-stated LW → read drops same cycle, no done_o, FSM IDLE. A new LW after reset completes normally.
6. With SVM_LSU_ALIGN_CHECK_EN: LW at 0x0002 → no read asserted, done_o and misaligned_o pulse at start+1, load_data_o unchanged.
